// File: rtl/histogram_sram_denetleyici.sv
// histogram_sram_denetleyici
// Frame sequencer and sole owner of the shared histogram SRAM (one write
// port, one read port, active-low chip selects). Each frame: clear all bins,
// hand both ports to the accumulation unit, then scan the bins and stream a
// saturating cumulative CDF to the equalisation stage.
module histogram_sram_denetleyici #(
  parameter int PIXEL_BIT = 8,
  parameter int VERI_BIT  = 17
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 temizle_i,
  input  logic                 tara_i,
  input  logic                 hb_wr_i,
  input  logic [PIXEL_BIT-1:0] hb_addr_w_i,
  input  logic [VERI_BIT-1:0]  hb_veri_i,
  input  logic                 hb_rd_i,
  input  logic [PIXEL_BIT-1:0] hb_addr_r_i,
  output logic [VERI_BIT-1:0]  hb_veri_o,
  output logic                 hb_izin_o,
  output logic                 sram_csb0_o,
  output logic [PIXEL_BIT-1:0] sram_addr0_o,
  output logic [VERI_BIT-1:0]  sram_din0_o,
  output logic                 sram_csb1_o,
  output logic [PIXEL_BIT-1:0] sram_addr1_o,
  input  logic [VERI_BIT-1:0]  sram_dout1_i,
  output logic [VERI_BIT-1:0]  cdf_o,
  output logic [PIXEL_BIT-1:0] cdf_piksel_o,
  output logic                 cdf_gecerli_o,
  output logic [VERI_BIT-1:0]  cdf_min_o,
  output logic                 tara_bitti_o,
  output logic                 mesgul_o,
  output logic                 hata_o
);

  typedef enum logic [1:0] {
    BOSTA,
    TEMIZLE,
    BIRIKTIR,
    TARA
  } durum_t;

  // Counter is one bit wider than the address: during a scan the extra
  // cycle (MSB set) drains the last SRAM read without issuing a new one.
  localparam logic [PIXEL_BIT:0] SON_ADR  = {1'b0, {PIXEL_BIT{1'b1}}};
  localparam logic [PIXEL_BIT:0] TARA_SON = {1'b1, {PIXEL_BIT{1'b0}}};

  durum_t                 r_durum;
  logic [PIXEL_BIT:0]     r_sayac;
  logic                   r_oku_gecerli;
  logic [PIXEL_BIT-1:0]   r_oku_adr;
  logic [VERI_BIT-1:0]    r_cdf;
  logic [PIXEL_BIT-1:0]   r_cdf_piksel;
  logic                   r_cdf_gecerli;
  logic [VERI_BIT-1:0]    r_cdf_min;
  logic                   r_tara_bitti;
  logic                   r_hata;

  logic [VERI_BIT:0]      w_toplam;
  logic [VERI_BIT-1:0]    w_cdf_sonraki;

  assign w_toplam      = {1'b0, r_cdf} + {1'b0, sram_dout1_i};
  assign w_cdf_sonraki = w_toplam[VERI_BIT] ? {VERI_BIT{1'b1}} : w_toplam[VERI_BIT-1:0];

  // Frame sequencer, scan read pipeline and registered CDF / status outputs.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_durum       <= BOSTA;
      r_sayac       <= '0;
      r_oku_gecerli <= 1'b0;
      r_oku_adr     <= '0;
      r_cdf         <= '0;
      r_cdf_piksel  <= '0;
      r_cdf_gecerli <= 1'b0;
      r_cdf_min     <= '0;
      r_tara_bitti  <= 1'b0;
      r_hata        <= 1'b0;
    end else begin
      r_hata        <= 1'b0;
      r_oku_gecerli <= 1'b0;
      r_cdf_gecerli <= r_oku_gecerli;
      r_tara_bitti  <= 1'b0;

      // Read data for bin r_oku_adr is on sram_dout1_i this cycle.
      if (r_oku_gecerli) begin
        r_cdf        <= w_cdf_sonraki;
        r_cdf_piksel <= r_oku_adr;
        r_tara_bitti <= (r_oku_adr == {PIXEL_BIT{1'b1}});
        if (r_cdf_min == '0) begin
          r_cdf_min <= w_cdf_sonraki;
        end
      end

      case (r_durum)
        BOSTA, BIRIKTIR: begin
          if (temizle_i) begin
            r_durum <= TEMIZLE;
            r_sayac <= '0;
            r_hata  <= tara_i;
          end else if (tara_i) begin
            r_durum   <= TARA;
            r_sayac   <= '0;
            r_cdf     <= '0;
            r_cdf_min <= '0;
          end
        end
        TEMIZLE: begin
          r_hata <= temizle_i | tara_i;
          if (r_sayac == SON_ADR) begin
            r_durum <= BIRIKTIR;
            r_sayac <= '0;
          end else begin
            r_sayac <= r_sayac + 1'b1;
          end
        end
        TARA: begin
          r_hata <= temizle_i | tara_i;
          if (r_sayac == TARA_SON) begin
            r_durum <= BOSTA;
            r_sayac <= '0;
          end else begin
            r_oku_gecerli <= 1'b1;
            r_oku_adr     <= r_sayac[PIXEL_BIT-1:0];
            r_sayac       <= r_sayac + 1'b1;
          end
        end
        default: begin
          r_durum <= BOSTA;
          r_sayac <= '0;
        end
      endcase
    end
  end

  // SRAM port ownership: each state decides who drives the two ports.
  always_comb begin
    sram_csb0_o  = 1'b1;
    sram_addr0_o = '0;
    sram_din0_o  = '0;
    sram_csb1_o  = 1'b1;
    sram_addr1_o = '0;
    case (r_durum)
      TEMIZLE: begin
        sram_csb0_o  = 1'b0;
        sram_addr0_o = r_sayac[PIXEL_BIT-1:0];
      end
      BIRIKTIR: begin
        sram_csb0_o  = ~hb_wr_i;
        sram_addr0_o = hb_addr_w_i;
        sram_din0_o  = hb_veri_i;
        sram_csb1_o  = ~hb_rd_i;
        sram_addr1_o = hb_addr_r_i;
      end
      TARA: begin
        sram_csb1_o  = r_sayac[PIXEL_BIT];
        sram_addr1_o = r_sayac[PIXEL_BIT-1:0];
      end
      default: begin
        sram_csb0_o = 1'b1;
        sram_csb1_o = 1'b1;
      end
    endcase
  end

  assign hb_veri_o     = sram_dout1_i;
  assign hb_izin_o     = (r_durum == BIRIKTIR);
  assign mesgul_o      = (r_durum == TEMIZLE) || (r_durum == TARA);
  assign cdf_o         = r_cdf;
  assign cdf_piksel_o  = r_cdf_piksel;
  assign cdf_gecerli_o = r_cdf_gecerli;
  assign cdf_min_o     = r_cdf_min;
  assign tara_bitti_o  = r_tara_bitti;
  assign hata_o        = r_hata;

endmodule

// File: tb/tb_histogram_sram_denetleyici.sv
// Bench for histogram_sram_denetleyici: a 256x17 SRAM model hangs off the
// DUT ports, the reference keeps the intended bin contents and derives the
// expected CDF as saturated prefix sums.
module tb_histogram_sram_denetleyici;
  localparam int PB = 8;
  localparam int VB = 17;
  localparam int unsigned MAXV = (1 << VB) - 1;

  logic          clk;
  logic          rstn;
  logic          temizle, tara;
  logic          hb_wr, hb_rd;
  logic [PB-1:0] hb_addr_w, hb_addr_r;
  logic [VB-1:0] hb_veri, hb_veri_o;
  logic          hb_izin;
  logic          sram_csb0, sram_csb1;
  logic [PB-1:0] sram_addr0, sram_addr1;
  logic [VB-1:0] sram_din0, sram_dout;
  logic [VB-1:0] cdf, cdf_min;
  logic [PB-1:0] cdf_piksel;
  logic          cdf_gecerli, tara_bitti, mesgul, hata;

  int total;
  int bad;
  int unsigned ref_bins[256];
  int unsigned exp_cdf[256];
  int unsigned exp_min;

  logic [VB-1:0] mem[256];
  logic          bozuk_yaz;

  histogram_sram_denetleyici #(.PIXEL_BIT(PB), .VERI_BIT(VB)) dut (
    .clk_i(clk), .rstn_i(rstn), .temizle_i(temizle), .tara_i(tara),
    .hb_wr_i(hb_wr), .hb_addr_w_i(hb_addr_w), .hb_veri_i(hb_veri),
    .hb_rd_i(hb_rd), .hb_addr_r_i(hb_addr_r), .hb_veri_o(hb_veri_o),
    .hb_izin_o(hb_izin), .sram_csb0_o(sram_csb0), .sram_addr0_o(sram_addr0),
    .sram_din0_o(sram_din0), .sram_csb1_o(sram_csb1), .sram_addr1_o(sram_addr1),
    .sram_dout1_i(sram_dout), .cdf_o(cdf), .cdf_piksel_o(cdf_piksel),
    .cdf_gecerli_o(cdf_gecerli), .cdf_min_o(cdf_min), .tara_bitti_o(tara_bitti),
    .mesgul_o(mesgul), .hata_o(hata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: synchronous write, one-cycle read latency, optional junk fill.
  always @(posedge clk) begin
    if (bozuk_yaz) begin
      for (int i = 0; i < 256; i++) mem[i] <= VB'($urandom);
    end else if (!sram_csb0) begin
      mem[sram_addr0] <= sram_din0;
    end
    if (!sram_csb1) sram_dout <= mem[sram_addr1];
  end

  function automatic void compute_expected();
    int unsigned s;
    s = 0;
    exp_min = 0;
    for (int k = 0; k < 256; k++) begin
      s = s + ref_bins[k];
      if (s > MAXV) s = MAXV;
      exp_cdf[k] = s;
      if (exp_min == 0) exp_min = s;
    end
  endfunction

  task automatic test_reset();
    rstn = 1'b0; temizle = 1'b0; tara = 1'b0;
    hb_wr = 1'b1; hb_rd = 1'b1; hb_addr_w = 8'h33; hb_addr_r = 8'h44; hb_veri = 17'h1234;
    bozuk_yaz = 1'b1;
    @(negedge clk);
    bozuk_yaz = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++; if ({sram_csb0, sram_csb1} !== 2'b11) begin
      bad++; $display("FAIL reset_csb got=%b exp=11", {sram_csb0, sram_csb1}); end
    total++; if ({sram_addr0, sram_din0, sram_addr1} !== '0) begin
      bad++; $display("FAIL reset_sram_bus got addr0=%0h din0=%0h addr1=%0h exp all 0", sram_addr0, sram_din0, sram_addr1); end
    total++; if ({cdf, cdf_piksel, cdf_min} !== '0) begin
      bad++; $display("FAIL reset_cdf got cdf=%0h piksel=%0h min=%0h exp all 0", cdf, cdf_piksel, cdf_min); end
    total++; if ({cdf_gecerli, tara_bitti, mesgul, hata, hb_izin} !== 5'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000", {cdf_gecerli, tara_bitti, mesgul, hata, hb_izin}); end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    total++; if (sram_csb0 !== 1'b1 || sram_csb1 !== 1'b1 || mesgul !== 1'b0 || hb_izin !== 1'b0) begin
      bad++; $display("FAIL idle_hb_blocked got csb0=%b csb1=%b mesgul=%b izin=%b exp 1 1 0 0", sram_csb0, sram_csb1, mesgul, hb_izin); end
    hb_wr = 1'b0; hb_rd = 1'b0;
  endtask

  // Clear from BOSTA; optionally with both commands at once, and optionally a
  // stray tara_i at clear cycle inj (inj < 0 means none).
  task automatic test_clear(input bit both, input int inj);
    @(negedge clk);
    hb_wr = 1'b0; hb_rd = 1'b0; temizle = 1'b1; tara = both;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      temizle = 1'b0;
      tara = (i == inj);
      hb_wr = 1'($urandom); hb_addr_w = PB'($urandom); hb_veri = VB'($urandom) | 17'h1;
      #1;
      total++; if (sram_csb0 !== 1'b0 || sram_addr0 !== PB'(i) || sram_din0 !== '0) begin
        bad++; $display("FAIL clear_write i=%0d got csb0=%b addr0=%0d din0=%0h exp 0 %0d 0", i, sram_csb0, sram_addr0, sram_din0, i); end
      total++; if (sram_csb1 !== 1'b1 || mesgul !== 1'b1 || hb_izin !== 1'b0) begin
        bad++; $display("FAIL clear_status i=%0d got csb1=%b mesgul=%b izin=%b exp 1 1 0", i, sram_csb1, mesgul, hb_izin); end
      total++; if (hata !== ((i == 0) ? both : (i == inj + 1))) begin
        bad++; $display("FAIL clear_hata i=%0d got=%b exp=%b", i, hata, (i == 0) ? both : (i == inj + 1)); end
    end
    @(negedge clk);
    tara = 1'b0; hb_wr = 1'b0;
    #1;
    total++; if (hb_izin !== 1'b1 || mesgul !== 1'b0 || sram_csb0 !== 1'b1 || hata !== 1'b0) begin
      bad++; $display("FAIL clear_done got izin=%b mesgul=%b csb0=%b hata=%b exp 1 0 1 0", hb_izin, mesgul, sram_csb0, hata); end
    for (int i = 0; i < 256; i++) ref_bins[i] = 0;
  endtask

  task automatic test_passthrough();
    logic [PB-1:0] wa, ra;
    logic [VB-1:0] wd;
    int unsigned prev_exp;
    bit prev_rd;
    @(negedge clk);
    hb_wr = 1'b1; hb_addr_w = 8'h12; hb_veri = 17'd5; hb_rd = 1'b0;
    #1;
    total++; if (sram_csb0 !== 1'b0 || sram_addr0 !== 8'h12 || sram_din0 !== 17'd5 || hb_izin !== 1'b1) begin
      bad++; $display("FAIL pass_write got csb0=%b addr0=%0h din0=%0h izin=%b exp 0 12 5 1", sram_csb0, sram_addr0, sram_din0, hb_izin); end
    ref_bins[8'h12] = 5;
    @(negedge clk);
    hb_wr = 1'b0; hb_rd = 1'b1; hb_addr_r = 8'h12;
    #1;
    total++; if (sram_csb1 !== 1'b0 || sram_addr1 !== 8'h12 || sram_csb0 !== 1'b1) begin
      bad++; $display("FAIL pass_read got csb1=%b addr1=%0h csb0=%b exp 0 12 1", sram_csb1, sram_addr1, sram_csb0); end
    @(negedge clk);
    hb_rd = 1'b0;
    #1;
    total++; if (hb_veri_o !== 17'd5) begin
      bad++; $display("FAIL pass_rdata got=%0h exp=5", hb_veri_o); end
    prev_rd = 1'b0; prev_exp = 0;
    for (int j = 0; j < 24; j++) begin
      @(negedge clk);
      if (prev_rd) begin
        total++; if (hb_veri_o !== VB'(prev_exp)) begin
          bad++; $display("FAIL pass_rand_rdata j=%0d got=%0h exp=%0h", j, hb_veri_o, prev_exp); end
      end
      wa = PB'($urandom); ra = PB'($urandom); wd = VB'($urandom);
      hb_wr = 1'($urandom); hb_rd = 1'($urandom);
      hb_addr_w = wa; hb_veri = wd; hb_addr_r = ra;
      #1;
      total++; if (sram_csb0 !== ~hb_wr || sram_csb1 !== ~hb_rd || sram_addr1 !== ra ||
                   (hb_wr && (sram_addr0 !== wa || sram_din0 !== wd))) begin
        bad++; $display("FAIL pass_rand j=%0d got csb0=%b csb1=%b a0=%0h d0=%0h a1=%0h exp %b %b %0h %0h %0h",
                        j, sram_csb0, sram_csb1, sram_addr0, sram_din0, sram_addr1, ~hb_wr, ~hb_rd, wa, wd, ra); end
      prev_rd = hb_rd;
      prev_exp = ref_bins[ra];
      if (hb_wr) ref_bins[wa] = wd;
    end
    @(negedge clk);
    if (prev_rd) begin
      total++; if (hb_veri_o !== VB'(prev_exp)) begin
        bad++; $display("FAIL pass_rand_rdata_last got=%0h exp=%0h", hb_veri_o, prev_exp); end
    end
    hb_wr = 1'b0; hb_rd = 1'b0;
  endtask

  task automatic load_bins();
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      hb_wr = 1'b1; hb_rd = 1'b0; hb_addr_w = PB'(a); hb_veri = VB'(ref_bins[a]);
    end
    @(negedge clk);
    hb_wr = 1'b0;
  endtask

  // Scan from BIRIKTIR. wr_on_tara adds an accumulator write in the tara_i
  // cycle; inj injects a temizle_i at scan cycle inj (inj < 0 means none).
  task automatic test_scan(input bit wr_on_tara, input int inj);
    logic [PB-1:0] wa;
    logic [VB-1:0] wd;
    int beat, busy;
    @(negedge clk);
    wa = PB'($urandom); wd = VB'($urandom);
    tara = 1'b1; temizle = 1'b0; hb_rd = 1'b0;
    hb_wr = wr_on_tara; hb_addr_w = wa; hb_veri = wd;
    #1;
    total++; if (sram_csb0 !== ~wr_on_tara) begin
      bad++; $display("FAIL scan_entry_write got csb0=%b exp=%b", sram_csb0, ~wr_on_tara); end
    if (wr_on_tara) ref_bins[wa] = wd;
    compute_expected();
    beat = 0; busy = 0;
    for (int c = 1; c <= 300 && beat < 256; c++) begin
      @(negedge clk);
      tara = 1'b0; temizle = (c == inj);
      hb_wr = 1'($urandom); hb_rd = 1'($urandom);
      hb_addr_w = PB'($urandom); hb_addr_r = PB'($urandom); hb_veri = VB'($urandom);
      #1;
      if (mesgul) busy++;
      if (c <= 256) begin
        total++; if (sram_csb1 !== 1'b0 || sram_addr1 !== PB'(c - 1) || sram_csb0 !== 1'b1 || hb_izin !== 1'b0) begin
          bad++; $display("FAIL scan_read c=%0d got csb1=%b addr1=%0d csb0=%b izin=%b exp 0 %0d 1 0", c, sram_csb1, sram_addr1, sram_csb0, hb_izin, c - 1); end
      end else if (c == 257) begin
        total++; if (sram_csb1 !== 1'b1 || sram_csb0 !== 1'b1) begin
          bad++; $display("FAIL scan_drain got csb1=%b csb0=%b exp 1 1", sram_csb1, sram_csb0); end
      end
      total++; if (hata !== (c == inj + 1)) begin
        bad++; $display("FAIL scan_hata c=%0d got=%b exp=%b", c, hata, (c == inj + 1)); end
      if (cdf_gecerli) begin
        total++; if (cdf_piksel !== PB'(beat) || cdf !== VB'(exp_cdf[beat]) || tara_bitti !== (beat == 255)) begin
          bad++; $display("FAIL scan_beat k=%0d got piksel=%0d cdf=%0h bitti=%b exp %0d %0h %b",
                          beat, cdf_piksel, cdf, tara_bitti, beat, exp_cdf[beat], (beat == 255)); end
        beat++;
      end else begin
        total++; if (beat != 0 || tara_bitti !== 1'b0) begin
          bad++; $display("FAIL scan_gap c=%0d got beats=%0d bitti=%b exp 0 0", c, beat, tara_bitti); end
      end
    end
    total++; if (beat != 256) begin
      bad++; $display("FAIL scan_beats got=%0d exp=256", beat); end
    total++; if (busy != 257) begin
      bad++; $display("FAIL scan_busy got=%0d exp=257", busy); end
    total++; if (cdf_min !== VB'(exp_min)) begin
      bad++; $display("FAIL scan_min got=%0h exp=%0h", cdf_min, exp_min); end
    @(negedge clk);
    temizle = 1'b0; hb_wr = 1'b0; hb_rd = 1'b0;
    #1;
    total++; if (cdf_gecerli !== 1'b0 || tara_bitti !== 1'b0 || mesgul !== 1'b0 || cdf_min !== VB'(exp_min)) begin
      bad++; $display("FAIL scan_after got gec=%b bitti=%b mesgul=%b min=%0h exp 0 0 0 %0h", cdf_gecerli, tara_bitti, mesgul, cdf_min, exp_min); end
  endtask

  task automatic test_reset_mid_scan();
    bit found;
    compute_expected();
    @(negedge clk);
    tara = 1'b1; hb_wr = 1'b0; hb_rd = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      tara = 1'b0;
      #1;
      if (cdf_gecerli && cdf_piksel == 8'd100) found = 1'b1;
    end
    total++; if (!found || cdf !== VB'(exp_cdf[100]) || cdf_min !== VB'(exp_min)) begin
      bad++; $display("FAIL midscan_k100 got found=%b cdf=%0h min=%0h exp 1 %0h %0h", found, cdf, cdf_min, exp_cdf[100], exp_min); end
    rstn = 1'b0;
    @(negedge clk);
    #1;
    total++; if (cdf_gecerli !== 1'b0 || sram_csb1 !== 1'b1 || mesgul !== 1'b0 || hb_izin !== 1'b0 || cdf_min !== '0 || cdf !== '0) begin
      bad++; $display("FAIL midscan_reset got gec=%b csb1=%b mesgul=%b izin=%b min=%0h cdf=%0h exp 0 1 0 0 0 0",
                      cdf_gecerli, sram_csb1, mesgul, hb_izin, cdf_min, cdf); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    bozuk_yaz = 1'b0;
    test_reset();
    test_clear(1'b0, -1);
    test_passthrough();

    for (int i = 0; i < 256; i++) ref_bins[i] = 0;
    ref_bins[3] = 4; ref_bins[200] = 10;
    load_bins();
    test_scan(1'b0, -1);

    test_clear(1'b1, 100);
    for (int i = 0; i < 256; i++) ref_bins[i] = MAXV;
    load_bins();
    test_scan(1'b0, 50);

    for (int r = 0; r < 2; r++) begin
      test_clear(1'b0, -1);
      for (int i = 0; i < 256; i++) begin
        int unsigned sel;
        sel = $urandom_range(0, 9);
        ref_bins[i] = (sel < 6) ? 0 : (sel < 9) ? $urandom_range(1, 1000) : $urandom_range(0, MAXV);
      end
      load_bins();
      test_scan(1'b1, -1);
    end

    test_clear(1'b0, -1);
    for (int i = 0; i < 256; i++) ref_bins[i] = $urandom_range(0, 50);
    ref_bins[0] = 7;
    load_bins();
    test_reset_mid_scan();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
